commit_trace_streamer: RTL

- Hardware-side source of the per-instruction state the single-cycle core's bench prints today.
- Captures one commit record per retired instruction from risc_v_processor: PC, register write-back and data-memory store.
- Buffers records in a small FIFO and streams each one out as three 32-bit words over a valid/ready interface, to a UART or debug host.
- Records are dropped and counted when the buffer overflows; the core is never stalled.

---
 rtl/commit_trace_streamer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/commit_trace_streamer.sv
// rtl/commit_trace_streamer.sv - commit record capture FIFO and three-word trace streamer
//
// Captures one record per retired instruction (header, PC, data word) into a
// DEPTH-record FIFO and streams each record as three 32-bit words. Overflowing
// records are dropped and counted; the core is never stalled.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   trace_en          capture enable (disabled commits are neither stored nor counted)
//   commit_*          retiring instruction PC
//   rd_we/addr/data   register write-back
//   mem_we/addr/wdata data-memory store
//   out_valid/out_data/out_ready/out_last  word stream, out_last on the third word
//   drop_count        saturating count of records lost to overflow
//   fifo_level        records currently buffered (0..DEPTH)

module commit_trace_streamer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trace_en,
   input  logic             commit_valid,
   input  logic [31:0]      commit_pc,
   input  logic             rd_we,
   input  logic [4:0]       rd_addr,
   input  logic [31:0]      rd_data,
   input  logic             mem_we,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ready,
   output logic             out_last,
   output logic [15:0]      drop_count,
   output logic [PTR_W:0]   fifo_level
);

   localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] LEVEL_ONE  = (PTR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

   state_t           state;
   logic [31:0]      hdr_mem [DEPTH];
   logic [31:0]      pc_mem  [DEPTH];
   logic [31:0]      dat_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [7:0]       seq;
   logic             pend_drop;
   logic             push;
   logic             pop;
   logic             accept;
   logic             wb;
   logic [31:0]      rec_hdr;
   logic [31:0]      rec_w2;
   logic [PTR_W:0]   level_nxt;

   // Only the low half of the store address is carried in the header.
   logic             unused_addr_hi;
   assign unused_addr_hi = ^mem_addr[31:16];

   always_comb begin
      wb         = rd_we & (rd_addr != 5'd0);
      rec_hdr    = {seq, pend_drop, wb, mem_we, rd_addr,
                    mem_we ? mem_addr[15:0] : 16'h0000};
      rec_w2     = wb ? rd_data : (mem_we ? mem_wdata : 32'h0000_0000);
      push       = commit_valid & trace_en;
      pop        = (state == W2) & out_ready;
      // A full FIFO still takes the push when the head leaves in the same cycle.
      accept     = push & ((fifo_level != LEVEL_FULL) | pop);
      rd_ptr_nxt = rd_ptr + 1'b1;
      level_nxt  = fifo_level;
      if (accept & ~pop) begin
         level_nxt = fifo_level + 1'b1;
      end else if (pop & ~accept) begin
         level_nxt = fifo_level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         hdr_mem[wr_ptr] <= rec_hdr;
         pc_mem[wr_ptr]  <= commit_pc;
         dat_mem[wr_ptr] <= rec_w2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_data   <= 32'h0000_0000;
         out_last   <= 1'b0;
         drop_count <= 16'h0000;
         fifo_level <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         seq        <= 8'h00;
         pend_drop  <= 1'b0;
      end else begin
         fifo_level <= level_nxt;

         if (accept) begin
            wr_ptr    <= wr_ptr + 1'b1;
            seq       <= seq + 8'h01;
            pend_drop <= 1'b0;
         end else if (push) begin
            pend_drop <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'h0001;
            end
         end

         if (pop) begin
            rd_ptr <= rd_ptr_nxt;
         end

         case (state)
            IDLE: begin
               if (fifo_level != '0) begin
                  state     <= W0;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  out_data  <= hdr_mem[rd_ptr];
               end
            end
            W0: begin
               if (out_ready) begin
                  state    <= W1;
                  out_data <= pc_mem[rd_ptr];
               end
            end
            W1: begin
               if (out_ready) begin
                  state    <= W2;
                  out_data <= dat_mem[rd_ptr];
                  out_last <= 1'b1;
               end
            end
            W2: begin
               if (out_ready) begin
                  out_last <= 1'b0;
                  if (level_nxt != '0) begin
                     state <= W0;
                     // With one record left, the next head is the one being
                     // written on this very edge, so take it straight from the input.
                     out_data <= (fifo_level == LEVEL_ONE) ? rec_hdr : hdr_mem[rd_ptr_nxt];
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_data  <= 32'h0000_0000;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
